// File: rtl/hilo_muldiv_ctrl_if.sv
// EX-stage <-> HI/LO multiply/divide sequencer connection.
// The master (EX stage) presents ops and reads; the slave (sequencer) returns stall/status and HI/LO.
interface hilo_muldiv_ctrl_if;
    logic        Start;
    logic [3:0]  Op;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic        HiLoRead;
    logic        Stall;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output Start, Op, OpA, OpB, HiLoRead,
        input  Stall, Busy, Done, HI, LO
    );

    modport slave (
        input  Start, Op, OpA, OpB, HiLoRead,
        output Stall, Busy, Done, HI, LO
    );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/MADD/MSUB/DIV/DIVU sequencer owning the HI/LO pair.
// Division is restoring, one quotient bit per cycle, with a sign-fix cycle at the end.
module hilo_muldiv_ctrl #(
    parameter int unsigned MUL_LAT   = 4,
    parameter int unsigned DIV_ITERS = 32
) (
    input  logic                Clk,
    input  logic                Reset,
    hilo_muldiv_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_MADD  = 4'd2;
    localparam logic [3:0] OP_MSUB  = 4'd3;
    localparam logic [3:0] OP_DIV   = 4'd4;
    localparam logic [3:0] OP_DIVU  = 4'd5;
    localparam logic [3:0] OP_MTHI  = 4'd6;
    localparam logic [3:0] OP_MTLO  = 4'd7;

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] rem_q, rem_d, quot_q, quot_d;
    logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic        divz_q, divz_d;
    logic        done_q, done_d;

    // Signed ops multiply sign-extended operands; the low 64 bits are the exact signed product.
    logic        mul_signed;
    logic [63:0] ext_a, ext_b, prod, acc;
    logic [32:0] rem_sh, trial;
    logic        is_div;

    assign mul_signed = (op_q != OP_MULTU);
    assign ext_a      = mul_signed ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    assign ext_b      = mul_signed ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    assign prod       = ext_a * ext_b;
    assign acc        = {hi_q, lo_q};
    assign rem_sh     = {rem_q, quot_q[31]};
    assign trial      = rem_sh - {1'b0, b_q};
    assign is_div     = (bus.Op == OP_DIV);

    // NOTE: every _d gets a default before the case so no path leaves a variable unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        divz_d    = divz_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    unique case (bus.Op)
                        OP_MTHI: hi_d = bus.OpA;
                        OP_MTLO: lo_d = bus.OpA;
                        OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                            a_d     = bus.OpA;
                            b_d     = bus.OpB;
                            op_d    = bus.Op;
                            cnt_d   = 5'(MUL_LAT - 1);
                            state_d = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            a_d       = bus.OpA;
                            op_d      = bus.Op;
                            neg_quo_d = is_div & (bus.OpA[31] ^ bus.OpB[31]);
                            neg_rem_d = is_div & bus.OpA[31];
                            quot_d    = (is_div && bus.OpA[31]) ? -bus.OpA : bus.OpA;
                            b_d       = (is_div && bus.OpB[31]) ? -bus.OpB : bus.OpB;
                            rem_d     = '0;
                            divz_d    = (bus.OpB == '0);
                            cnt_d     = 5'(DIV_ITERS - 1);
                            state_d   = (bus.OpB == '0) ? S_FIX : S_DIV;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == '0) begin
                    unique case (op_q)
                        OP_MADD: {hi_d, lo_d} = acc + prod;
                        OP_MSUB: {hi_d, lo_d} = acc - prod;
                        default: {hi_d, lo_d} = prod;
                    endcase
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                if (!trial[32]) begin
                    rem_d  = trial[31:0];
                    quot_d = {quot_q[30:0], 1'b1};
                end else begin
                    rem_d  = rem_sh[31:0];
                    quot_d = {quot_q[30:0], 1'b0};
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (divz_q) begin
                    lo_d = 32'hFFFF_FFFF;
                    hi_d = a_q;
                end else begin
                    lo_d = neg_quo_q ? -quot_q : quot_q;
                    hi_d = neg_rem_q ? -rem_q : rem_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            divz_q    <= divz_d;
            done_q    <= done_d;
        end
    end

    // A read or new op during an in-flight op must hold the pipeline until HI/LO settle.
    assign bus.Stall = (bus.Start | bus.HiLoRead) & (state_q != S_IDLE);
    assign bus.Busy  = (state_q != S_IDLE);
    assign bus.Done  = done_q;
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl with hand-computed HI/LO, Busy-length and Stall expectations.
module tb_hilo_muldiv_ctrl;
    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;
    int   cnt;

    hilo_muldiv_ctrl_if bus ();

    hilo_muldiv_ctrl #(.MUL_LAT(4), .DIV_ITERS(32)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.OpA   = a;
        bus.OpB   = b;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.Busy && n < 200) begin
            @(posedge Clk);
            #1;
            n++;
        end
    endtask

    initial begin
        bus.Start    = 1'b0;
        bus.Op       = 4'd0;
        bus.OpA      = '0;
        bus.OpB      = '0;
        bus.HiLoRead = 1'b0;
        Reset        = 1'b0;
        #12;
        check("reset_hi", bus.HI, 32'h0);
        check("reset_lo", bus.LO, 32'h0);
        check("reset_busy", bus.Busy, 1'b0);
        check("reset_done", bus.Done, 1'b0);
        Reset = 1'b1;
        @(posedge Clk);
        #1;

        // MULT -3 * 5
        issue(4'd0, 32'hFFFF_FFFD, 32'd5);
        check("mult_busy_start", bus.Busy, 1'b1);
        wait_idle(cnt);
        check("mult_busy_cycles", cnt, 32'd4);
        check("mult_done", bus.Done, 1'b1);
        check("mult_hi", bus.HI, 32'hFFFF_FFFF);
        check("mult_lo", bus.LO, 32'hFFFF_FFF1);
        @(posedge Clk);
        #1;
        check("mult_done_pulse", bus.Done, 1'b0);

        // MTHI / MTLO then MADD and MSUB
        issue(4'd6, 32'd0, 32'd0);
        check("mthi_hi", bus.HI, 32'h0);
        check("mthi_busy", bus.Busy, 1'b0);
        issue(4'd7, 32'd10, 32'd0);
        check("mtlo_lo", bus.LO, 32'd10);
        check("mtlo_done", bus.Done, 1'b0);
        issue(4'd2, 32'd3, 32'd4);
        wait_idle(cnt);
        check("madd_lo", bus.LO, 32'd22);
        check("madd_hi", bus.HI, 32'd0);
        issue(4'd3, 32'd2, 32'd20);
        wait_idle(cnt);
        check("msub_hi", bus.HI, 32'hFFFF_FFFF);
        check("msub_lo", bus.LO, 32'hFFFF_FFEE);

        // DIVU 100/7, DIV -7/2, DIV overflow case
        issue(4'd5, 32'd100, 32'd7);
        wait_idle(cnt);
        check("divu_busy_cycles", cnt, 32'd33);
        check("divu_done", bus.Done, 1'b1);
        check("divu_lo", bus.LO, 32'd14);
        check("divu_hi", bus.HI, 32'd2);
        issue(4'd4, 32'hFFFF_FFF9, 32'd2);
        wait_idle(cnt);
        check("div_neg_lo", bus.LO, 32'hFFFF_FFFD);
        check("div_neg_hi", bus.HI, 32'hFFFF_FFFF);
        issue(4'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cnt);
        check("div_ovf_lo", bus.LO, 32'h8000_0000);
        check("div_ovf_hi", bus.HI, 32'h0);

        // Divide by zero
        issue(4'd4, 32'h1234, 32'd0);
        check("divz_busy_start", bus.Busy, 1'b1);
        wait_idle(cnt);
        check("divz_busy_cycles", cnt, 32'd1);
        check("divz_done", bus.Done, 1'b1);
        check("divz_lo", bus.LO, 32'hFFFF_FFFF);
        check("divz_hi", bus.HI, 32'h1234);

        // HiLoRead in cycle 2 of MULT stalls until idle, then sees the product
        issue(4'd0, 32'd6, 32'd7);
        @(posedge Clk);
        #1;
        bus.HiLoRead = 1'b1;
        #1;
        check("read_stall", bus.Stall, 1'b1);
        cnt = 0;
        while (bus.Stall && cnt < 50) begin
            @(posedge Clk);
            #1;
            cnt++;
        end
        check("read_stall_cycles", cnt, 32'd3);
        check("read_idle_busy", bus.Busy, 1'b0);
        check("read_lo", bus.LO, 32'd42);
        check("read_hi", bus.HI, 32'd0);
        bus.HiLoRead = 1'b0;

        // DIVU presented during MUL: held off, accepted in the Done cycle
        issue(4'd0, 32'd3, 32'd3);
        bus.Start = 1'b1;
        bus.Op    = 4'd5;
        bus.OpA   = 32'd50;
        bus.OpB   = 32'd8;
        #1;
        check("start_stall", bus.Stall, 1'b1);
        cnt = 0;
        while (bus.Stall && cnt < 50) begin
            @(posedge Clk);
            #1;
            cnt++;
        end
        check("start_stall_cycles", cnt, 32'd4);
        check("start_done_cycle", bus.Done, 1'b1);
        check("start_mul_lo", bus.LO, 32'd9);
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        check("start_accepted", bus.Busy, 1'b1);
        wait_idle(cnt);
        check("start_div_cycles", cnt, 32'd33);
        check("start_div_lo", bus.LO, 32'd6);
        check("start_div_hi", bus.HI, 32'd2);

        // Start and HiLoRead together in IDLE: no stall, read sees pre-op value
        bus.HiLoRead = 1'b1;
        bus.Start    = 1'b1;
        bus.Op       = 4'd7;
        bus.OpA      = 32'd99;
        #1;
        check("both_stall", bus.Stall, 1'b0);
        check("both_pre_lo", bus.LO, 32'd6);
        @(posedge Clk);
        #1;
        bus.Start    = 1'b0;
        bus.HiLoRead = 1'b0;
        check("both_post_lo", bus.LO, 32'd99);

        // Undefined op code has no effect
        issue(4'd9, 32'd55, 32'd1);
        check("nop_busy", bus.Busy, 1'b0);
        check("nop_hi", bus.HI, 32'd2);
        check("nop_lo", bus.LO, 32'd99);

        // Reset mid-DIV (counter at 10) abandons the op
        issue(4'd4, 32'd1000, 32'd3);
        repeat (21) @(posedge Clk);
        #1;
        check("middiv_busy", bus.Busy, 1'b1);
        Reset = 1'b0;
        #1;
        check("middiv_rst_hi", bus.HI, 32'h0);
        check("middiv_rst_lo", bus.LO, 32'h0);
        check("middiv_rst_busy", bus.Busy, 1'b0);
        check("middiv_rst_done", bus.Done, 1'b0);
        #2;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        issue(4'd7, 32'd5, 32'd0);
        check("post_rst_lo", bus.LO, 32'd5);
        check("post_rst_hi", bus.HI, 32'd0);
        check("post_rst_busy", bus.Busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer that owns the HI/LO register pair of the pipelined MIPS datapath. It accepts an operation from the EX stage, runs it over several cycles, and writes HI/LO on completion. It stalls the pipeline when a new mul/div op or an MFHI/MFLO read arrives while an operation is in flight. HIRegOutput/LORegOutput of the datapath are driven from this block's HI/LO outputs.

Parameters:
MUL_LAT, 4, cycles from accept to HI/LO write for MULT/MULTU/MADD/MSUB (legal range 1..15)
DIV_ITERS, 32, restoring-division iterations (fixed at data width; not to be changed)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset (0 = reset)
Start  input  1  EX stage presents a HI/LO-writing op this cycle
Op  input  4  0=MULT 1=MULTU 2=MADD 3=MSUB 4=DIV 5=DIVU 6=MTHI 7=MTLO; others = no-op
OpA  input  32  rs operand
OpB  input  32  rt operand
HiLoRead  input  1  EX stage holds MFHI/MFLO this cycle
Stall  output  1  combinational; freeze PC and IF/ID/ID-EX
Busy  output  1  registered; state != IDLE
Done  output  1  registered one-cycle pulse after HI/LO update by mul/div
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset (async, Reset=0): state=IDLE, HI=0, LO=0, Busy=0, Done=0, counter=0, operand latches=0. Any op in flight is abandoned; no partial HI/LO write.
- States: IDLE, MUL, DIV, FIX.
- Stall = (Start | HiLoRead) & (state != IDLE). Start while not IDLE is ignored internally; the pipeline holds and re-presents the op once Stall drops.
- IDLE, Start, Op=MTHI/MTLO: HI (or LO) <= OpA at the edge; stay IDLE; no Busy, no Done.
- IDLE, Start, Op=0..3: latch OpA/OpB/Op; counter <= MUL_LAT-1; go to MUL.
- MUL: counter decrements each edge. At the edge with counter==0, compute the 64-bit product. MULT/MADD/MSUB are signed; MULTU is unsigned. Write {HI,LO} <= product (MULT/MULTU), {HI,LO}+product (MADD), or {HI,LO}-product (MSUB), with 64-bit wrap-around. Then go to IDLE and set Done=1 for one cycle.
- Net MUL timing: accept at edge k; Busy=1 for MUL_LAT cycles; HI/LO valid after edge k+MUL_LAT.
- IDLE, Start, Op=4/5, OpB!=0: latch magnitudes (DIV: |OpA|, |OpB| plus sign flags; DIVU: raw); counter <= 31; go to DIV.
- DIV: one restoring step per edge (shift remainder, trial subtract, set quotient bit); counter decrements. At counter==0, go to FIX.
- FIX: quotient is negated if the operand signs differ (DIV only); remainder takes the sign of the dividend. LO <= quotient, HI <= remainder. Then go to IDLE with Done=1.
- DIV timing: 33 cycles Busy.
- Div by zero (Op=4/5, OpB==0): go directly to FIX, which writes LO=32'hFFFFFFFF and HI=OpA. Busy 1 cycle, Done pulses.
- DIV of 32'h80000000 by 32'hFFFFFFFF: LO=32'h80000000, HI=0 (wraps, no trap).
- Op codes 8..15 with Start in IDLE: no effect.
- HiLoRead in IDLE: Stall=0; HI/LO are readable combinationally the same cycle.
- Start and HiLoRead both high in IDLE: the op is accepted, Stall=0. The read returns pre-op HI/LO (program order: the read is older).
- Done and Start in the same cycle (state IDLE): the new op is accepted normally.

Test Plan:
- Reset=0 mid-DIV (counter=10) -> HI=0, LO=0, Busy=0 immediately; after release, IDLE and MTLO 32'h5 -> LO=5 next edge.
- MULT OpA=-3 (32'hFFFFFFFD), OpB=5 -> after MUL_LAT=4 edges HI=32'hFFFFFFFF, LO=32'hFFFFFFF1; Done one cycle; Busy 4 cycles.
- MTHI 0, MTLO 10, then MADD 3*4 -> LO=22, HI=0. Then MSUB 2*20 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFEE.
- DIVU 100/7 -> LO=14, HI=2 after 33 Busy cycles. DIV -7/2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- HiLoRead asserted at cycle 2 of a MULT -> Stall=1 until state returns to IDLE; the read then sees the product. Start of DIVU during MUL -> Stall=1; accepted the cycle after Done.
- DIV by zero, OpA=32'h1234 -> Busy 1 cycle, LO=32'hFFFFFFFF, HI=32'h1234.
